// File: rtl/ex_stage_p.sv
// ex_stage_p: parametrised execute stage (ID/EX -> EX/MEM).
// Evaluates ALU result / branch target / branch condition, carries B and IR
// forward, with a valid/ready handshake on both sides and an iterative
// shift-add multiplier that holds off upstream while it runs.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   flush               synchronous kill of in-flight and output instructions
//   in_valid/in_ready   upstream handshake
//   ir_i, npc_i, a_i, b_i, imm_i   instruction, PC+4, operands, immediate
//   out_valid/out_ready downstream handshake
//   cond_o, alu_o, b_o, ir_o, ovf_o  EX/MEM register contents
//   busy                multiplier FSM not idle
module ex_stage_p #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ir_i,
  input  logic [XLEN-1:0] npc_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            cond_o,
  output logic [XLEN-1:0] alu_o,
  output logic [XLEN-1:0] b_o,
  output logic [31:0]     ir_o,
  output logic            ovf_o,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

  state_t state, state_nx;

  logic [5:0]      op, funct;
  logic [XLEN-1:0] sum_ab, dif_ab, sum_ai, br_tgt;
  logic            ovf_add, ovf_sub, ovf_addi, slt_lt;
  logic [XLEN-1:0] res;
  logic            res_cond, res_ovf, is_mult;

  logic            out_free, accept, mul_start, load_sc, wb_done, mul_last;

  logic [XLEN-1:0] mcand, mplier, acc, m_b;
  logic [31:0]     m_ir;
  logic [CW-1:0]   cnt;

  // ---------------------------------------------------------------- decode
  assign op     = ir_i[31:26];
  assign funct  = ir_i[5:0];
  assign sum_ab = a_i + b_i;
  assign dif_ab = a_i - b_i;
  assign sum_ai = a_i + imm_i;
  assign br_tgt = npc_i + (imm_i << 2);
  assign slt_lt = $signed(a_i) < $signed(b_i);

  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign departs from A.
  assign ovf_add  = (a_i[XLEN-1] == b_i[XLEN-1])   & (sum_ab[XLEN-1] != a_i[XLEN-1]);
  assign ovf_sub  = (a_i[XLEN-1] != b_i[XLEN-1])   & (dif_ab[XLEN-1] != a_i[XLEN-1]);
  assign ovf_addi = (a_i[XLEN-1] == imm_i[XLEN-1]) & (sum_ai[XLEN-1] != a_i[XLEN-1]);

  always_comb begin
    res      = '0;
    res_cond = 1'b0;
    res_ovf  = 1'b0;
    is_mult  = 1'b0;
    unique case (op)
      OP_R: begin
        unique case (funct)
          FN_ADD:  begin res = sum_ab; res_ovf = ovf_add; end
          FN_SUB:  begin res = dif_ab; res_ovf = ovf_sub; end
          FN_AND:  res = a_i & b_i;
          FN_OR:   res = a_i | b_i;
          FN_XOR:  res = a_i ^ b_i;
          FN_SLT:  res = {{(XLEN-1){1'b0}}, slt_lt};
          FN_MULT: is_mult = MUL_EN;
          default: ;
        endcase
      end
      OP_ADDI:       begin res = sum_ai; res_ovf = ovf_addi; end
      OP_ANDI:       res = a_i & imm_i;
      OP_ORI:        res = a_i | imm_i;
      OP_LW, OP_SW:  res = sum_ai;
      OP_BEQ:        begin res = br_tgt; res_cond = (a_i == b_i); end
      OP_BNE:        begin res = br_tgt; res_cond = (a_i != b_i); end
      default: ;
    endcase
  end

  // ------------------------------------------------------------ handshake
  assign out_free  = !out_valid | out_ready;
  assign in_ready  = (state == S_IDLE) & out_free & !flush;
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & is_mult;
  assign load_sc   = accept & !is_mult;
  assign wb_done   = (state == S_WB) & out_free & !flush;
  assign mul_last  = (cnt == CW'(1));
  assign busy      = (state != S_IDLE);

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (mul_start) state_nx = S_MUL;
      S_MUL:   if (mul_last)  state_nx = S_WB;
      S_WB:    if (wb_done)   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // ----------------------------------------------------------- multiplier
  // Shift-add over XLEN cycles; only the low XLEN product bits are kept, so
  // the multiplicand can shift within XLEN bits.
  if (MUL_EN) begin : g_mul
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mcand  <= '0;
        mplier <= '0;
        acc    <= '0;
        cnt    <= '0;
        m_ir   <= '0;
        m_b    <= '0;
      end else if (mul_start) begin
        mcand  <= a_i;
        mplier <= b_i;
        acc    <= '0;
        cnt    <= CW'(XLEN);
        m_ir   <= ir_i;
        m_b    <= b_i;
      end else if (state == S_MUL) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
    end
  end else begin : g_nomul
    assign mcand  = '0;
    assign mplier = '0;
    assign acc    = '0;
    assign cnt    = '0;
    assign m_ir   = '0;
    assign m_b    = '0;
  end

  // ------------------------------------------------------ output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      cond_o    <= 1'b0;
      alu_o     <= '0;
      b_o       <= '0;
      ir_o      <= '0;
      ovf_o     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_sc) begin
      out_valid <= 1'b1;
      cond_o    <= res_cond;
      alu_o     <= res;
      b_o       <= b_i;
      ir_o      <= ir_i;
      ovf_o     <= res_ovf;
    end else if (wb_done) begin
      out_valid <= 1'b1;
      cond_o    <= 1'b0;
      alu_o     <= acc;
      b_o       <= m_b;
      ir_o      <= m_ir;
      ovf_o     <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_p.sv
// Directed bench for ex_stage_p: a 32-bit instance carries most vectors, a
// 16-bit instance covers width-dependent wrap, overflow and mult latency.
module tb_ex_stage_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;

  // XLEN = 32 instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] ir = '0, npc = '0, a = '0, b = '0, imm = '0;
  logic        cond, ovf, busy;
  logic [31:0] alu, b_out, ir_out;

  // XLEN = 16 instance
  logic        s_vld = 1'b0, s_rdy, s_ovld, s_ordy = 1'b0;
  logic [31:0] s_ir = '0, s_ir_out;
  logic [15:0] s_npc = '0, s_a = '0, s_b = '0, s_imm = '0, s_alu, s_b_out;
  logic        s_cond, s_ovf, s_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_stage_p #(.XLEN(32), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ir_i(ir), .npc_i(npc), .a_i(a), .b_i(b), .imm_i(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .cond_o(cond), .alu_o(alu), .b_o(b_out), .ir_o(ir_out),
    .ovf_o(ovf), .busy(busy)
  );

  ex_stage_p #(.XLEN(16), .MUL_EN(1'b1)) u_dut16 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s_vld), .in_ready(s_rdy),
    .ir_i(s_ir), .npc_i(s_npc), .a_i(s_a), .b_i(s_b), .imm_i(s_imm),
    .out_valid(s_ovld), .out_ready(s_ordy),
    .cond_o(s_cond), .alu_o(s_alu), .b_o(s_b_out), .ir_o(s_ir_out),
    .ovf_o(s_ovf), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rty(input logic [5:0] f);
    return {26'b0, f};
  endfunction

  function automatic logic [31:0] ity(input logic [5:0] o);
    return {o, 26'b0};
  endfunction

  task automatic drv(input logic [31:0] i, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] iv, input logic [31:0] nv);
    ir = i; a = av; b = bv; imm = iv; npc = nv;
  endtask

  initial begin
    int n;
    logic seen, stable;

    // ---- reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu", alu, 0);
    chk("rst_b", b_out, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_cond_ovf_busy", {cond, ovf, busy}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // ---- single-cycle stream, one result per cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drv(rty(6'h20), 7, 5, 0, 0);
    tick;
    chk("add_alu", alu, 12);
    chk("add_vld_ovf", {out_valid, ovf}, 2'b10);
    chk("add_ir", ir_out, rty(6'h20));
    drv(rty(6'h22), 3, 5, 0, 0);
    tick;
    chk("sub_alu", alu, 32'hFFFF_FFFE);
    chk("sub_vld_ovf", {out_valid, ovf}, 2'b10);
    drv(rty(6'h2A), 32'hFFFF_FFFF, 1, 0, 0);
    tick;
    chk("slt_alu", alu, 1);
    drv(ity(6'h08), 32'h7FFF_FFFF, 0, 1, 0);
    tick;
    chk("addi_alu", alu, 32'h8000_0000);
    chk("addi_ovf", ovf, 1);
    // ---- branches
    drv(ity(6'h04), 9, 9, 3, 32'h100);
    tick;
    chk("beq_alu", alu, 32'h10C);
    chk("beq_cond", cond, 1);
    drv(ity(6'h05), 9, 9, 3, 32'h100);
    tick;
    chk("bne_alu", alu, 32'h10C);
    chk("bne_cond", cond, 0);
    // ---- unknown opcode is a NOP but still carried forward
    drv(32'hFC00_0000, 9, 9, 3, 32'h100);
    tick;
    chk("nop_res", {out_valid, cond, ovf, alu}, {3'b100, 32'h0});
    chk("nop_ir", ir_out, 32'hFC00_0000);
    in_valid = 1'b0;
    tick;
    chk("drain_vld", out_valid, 0);

    // ---- multiply: in_ready low for XLEN+1 cycles
    drv(rty(6'h18), 32'h1234, 32'h10, 0, 0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!in_ready && n < 100) begin
      n++;
      if (out_valid || !busy) seen = 1'b1;
      tick;
    end
    chk("mul_stall_cycles", n, 33);
    chk("mul_quiet_while_busy", seen, 0);
    chk("mul_alu", alu, 32'h12340);
    chk("mul_vld_b", {out_valid, b_out}, {1'b1, 32'h10});
    drv(rty(6'h20), 1, 2, 0, 0);
    in_valid = 1'b1;
    tick;
    chk("post_mul_add", {out_valid, alu}, {1'b1, 32'd3});
    in_valid = 1'b0;
    tick;

    // ---- back-pressure
    out_ready = 1'b0;
    drv(rty(6'h20), 2, 3, 0, 0);
    in_valid = 1'b1;
    tick;
    drv(rty(6'h20), 10, 20, 0, 0);
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (in_ready || !out_valid || alu != 5 || b_out != 3) stable = 1'b0;
      tick;
    end
    chk("bp_frozen", stable, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick;
    chk("bp_swap", {out_valid, alu, b_out}, {1'b1, 32'd30, 32'd20});
    in_valid = 1'b0;
    tick;

    // ---- flush mid-multiply
    drv(rty(6'h18), 32'h1234, 32'h10, 0, 0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    chk("fl_busy_before", busy, 1);
    flush = 1'b1;
    #1;
    chk("fl_in_ready_low", in_ready, 0);
    tick;
    flush = 1'b0;
    #1;
    chk("fl_after", {out_valid, busy, in_ready}, 3'b001);
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    chk("fl_no_product", seen, 0);

    // ---- async reset mid-multiply
    drv(rty(6'h18), 5, 7, 0, 0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    #2 rst = 1'b1;
    #1;
    chk("rst_mul_busy", {busy, out_valid}, 0);
    #1 rst = 1'b0;

    // ---- async reset while a result is stalled
    out_ready = 1'b0;
    drv(rty(6'h20), 7, 5, 0, 0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("stall_vld", {out_valid, alu}, {1'b1, 32'd12});
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {out_valid, cond, ovf, alu, b_out, ir_out}, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick;

    // ---- XLEN = 16
    s_ordy = 1'b1;
    s_vld  = 1'b1;
    s_ir = rty(6'h20); s_a = 16'hFFFF; s_b = 16'h0001;
    tick;
    chk("x16_wrap", {s_ovld, s_ovf, s_alu}, {2'b10, 16'h0000});
    s_a = 16'h7FFF;
    tick;
    chk("x16_ovf", {s_ovld, s_ovf, s_alu}, {2'b11, 16'h8000});
    s_ir = rty(6'h18); s_a = 16'h0012; s_b = 16'h0034;
    tick;
    s_vld = 1'b0;
    n = 0;
    while (!s_rdy && n < 100) begin
      n++;
      tick;
    end
    chk("x16_mul_cycles", n, 17);
    chk("x16_mul_alu", {s_ovld, s_alu}, {1'b1, 16'h03A8});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage_p.md
# ex_stage_p

Parametrised execute stage for the R/I/J pipeline, between the ID/EX and EX/MEM boundaries. It evaluates the ALU result, the branch target and the branch condition, and carries B and IR forward. It adds three things over the fixed 32-bit stage: a configurable datapath width, a valid/ready handshake on both sides with back-pressure, and an iterative multi-cycle multiplier that stalls the upstream stage while it runs.

## Interface
- XLEN, 32: datapath width; must be 16 or more. IR stays 32 bits.
- MUL_EN, 1: when 0, the mult funct decodes as NOP and no multiplier logic is built.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of the in-flight and output instructions.
- in_valid  in  1  ID/EX holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- ir_i  in  32  instruction word.
- npc_i  in  XLEN  PC+4 of the instruction.
- a_i, b_i  in  XLEN  rs and rt operands.
- imm_i  in  XLEN  sign-extended immediate.
- out_valid  out  1  EX/MEM register holds a result.
- out_ready  in  1  downstream consumes the result.
- cond_o  out  1  branch taken.
- alu_o  out  XLEN  ALU result or branch target.
- b_o  out  XLEN  a_i/b_i pass-through for stores: carries b_i.
- ir_o  out  32  instruction word.
- ovf_o  out  1  signed overflow flag.
- busy  out  1  multiplier FSM not in IDLE.

## Operation
- Decode: op = ir[31:26], funct = ir[5:0]. All arithmetic wraps modulo 2^XLEN.
- op 0x00 (R-type), selected by funct:
  - 0x20 add: A+B.
  - 0x22 sub: A−B.
  - 0x24 and, 0x25 or, 0x26 xor.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x18 mult: low XLEN bits of the unsigned product, computed on the multi-cycle path.
- I-type:
  - 0x08 addi: A+imm.
  - 0x0C andi, 0x0D ori.
  - 0x23 lw, 0x2B sw: A+imm.
- Branches: alu_o = npc + (imm<<2).
  - 0x04 beq: cond = (A==B).
  - 0x05 bne: cond = (A!=B).
- Any other op/funct is a NOP:
  - alu_o = 0, cond = 0, ovf = 0.
  - IR is still carried forward with out_valid.
- ovf_o: set only for add, sub and addi, on signed overflow. 0 for every other instruction.
- cond_o is 0 for every non-branch.
- FSM states:
  - IDLE: single-cycle ops are accepted here and written to the output register at the accepting edge. A mult is accepted into MUL, latching the multiplicand, multiplier, count = XLEN and the IR.
  - MUL: shift-add processes one multiplier bit per cycle and decrements count. When count reaches 0 go to WB.
  - WB: wait until the output register is free (!out_valid | out_ready), write the product, then go to IDLE.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
- Output register:
  - Loaded only on an accept in IDLE or on WB completion.
  - Cleared to invalid when out_ready is high and there is no new load.
  - Held stable while out_valid & !out_ready.

## Timing
- Reset: out_valid=0, cond_o=0, alu_o=0, b_o=0, ir_o=0, ovf_o=0, state=IDLE, busy=0. in_ready is 1 after reset.
- Single-cycle op latency: accept at edge N gives out_valid from N, visible in cycle N+1.
- mult latency: accept at edge N, then XLEN MUL cycles, then the WB write. Earliest out_valid is at edge N+XLEN+1.
- in_ready is 0 from the accept edge of a mult until WB completes. busy=1 over the same interval.
- Full throughput: with out_ready held at 1, one single-cycle instruction is accepted per cycle.
- Back-pressure: out_ready=0 while out_valid=1 forces in_ready=0, and all outputs are frozen.
- Simultaneous out_ready and accept in the same cycle: the old result drains and the new one loads in that same edge.
- flush at an edge:
  - out_valid ← 0, state ← IDLE.
  - Any multiply in progress is discarded.
  - No accept that cycle.
  - flush overrides in_valid and out_ready.
- rst asserted mid-multiply: immediate return to the reset values above.

## Test plan
- Single-cycle ops. Stream add 7+5, sub 3−5, slt(−1,1), addi 0x7FFFFFFF+1, each with out_ready=1 → alu_o sequence 12, 0xFFFFFFFE, 1, 0x80000000. ovf_o=1 only on the addi. One result per cycle.
- Branches. beq with A=B=9, npc=0x100, imm=3 → cond=1, alu_o=0x10C. bne with the same operands → cond=0, alu_o=0x10C.
- Multiply. mult 0x1234×0x10 at XLEN=32 → in_ready low for 33 cycles, then alu_o=0x12340. The next add is accepted the cycle after WB.
- Back-pressure. Hold out_ready=0 for 4 cycles after an add → outputs are stable and in_ready=0. Release → the next instruction is accepted in the same edge the old one drains.
- Flush mid-mult. flush after 10 MUL cycles → out_valid=0, busy=0, in_ready=1 next cycle, and no product is ever emitted.
- Async reset while a result is stalled. All outputs go to 0 immediately. With XLEN=16, add 0xFFFF+1 → alu_o=0.
